// File: rtl/demux4_pkg.sv
// Shared widths and slot encoding for the demux4_seq receive sequencer.
package demux4_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned SLOT_W  = 2;
    localparam int unsigned FRAME_W = 4 * DATA_W;

    typedef enum logic [SLOT_W-1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } slot_e;

endpackage

// File: rtl/prescaler_tick.sv
// Free-running NP-bit prescaler; tick is high while the count is all ones.
module prescaler_tick #(
    parameter int unsigned NP = 22
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    logic [NP-1:0] pcnt_q, pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q + NP'(1);
        if (clr) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign tick = &pcnt_q;

endmodule

// File: rtl/demux4_seq.sv
// 4-slot time-demultiplexer: collects one sample per tick, publishes a whole frame at once.
// Optional frame realignment via `sync` when DEMUX4_SYNC_EN is defined.
module demux4_seq
    import demux4_pkg::*;
#(
    parameter int unsigned NP = 22
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [DATA_W-1:0]  din,
    input  logic               sync,
    output logic [SLOT_W-1:0]  sel,
    output logic [FRAME_W-1:0] dout,
    output logic               frame
);

    logic tick;
    logic sync_act;

`ifdef DEMUX4_SYNC_EN
    assign sync_act = sync;
`else
    logic unused_sync;
    assign unused_sync = sync;
    assign sync_act    = 1'b0;
`endif

    prescaler_tick #(
        .NP (NP)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .clr  (sync_act),
        .tick (tick)
    );

    slot_e                         state_q, state_d;
    logic [2:0][DATA_W-1:0]        shadow_q, shadow_d;
    logic [FRAME_W-1:0]            dout_q, dout_d;
    logic                          frame_q, frame_d;
    logic                          full_pass_q, full_pass_d;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        dout_d      = dout_q;
        frame_d     = 1'b0;
        full_pass_d = full_pass_q;

        // Realignment wins over a coincident tick: nothing is captured on that edge.
        if (sync_act) begin
            state_d     = S0;
            shadow_d    = '0;
            full_pass_d = 1'b0;
        end else if (tick) begin
            unique case (state_q)
                S0: begin
                    shadow_d[0] = din;
                    full_pass_d = 1'b1;
                    state_d     = S1;
                end
                S1: begin
                    shadow_d[1] = din;
                    state_d     = S2;
                end
                S2: begin
                    shadow_d[2] = din;
                    state_d     = S3;
                end
                S3: begin
                    // Partial frames (no S0 capture since realign) are dropped.
                    if (full_pass_q) begin
                        dout_d  = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                        frame_d = 1'b1;
                    end
                    state_d = S0;
                end
                default: state_d = S0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S0;
            shadow_q    <= '0;
            dout_q      <= '0;
            frame_q     <= 1'b0;
            full_pass_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            dout_q      <= dout_d;
            frame_q     <= frame_d;
            full_pass_q <= full_pass_d;
        end
    end

    assign sel   = state_q;
    assign dout  = dout_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_demux4_seq.sv
// Directed, table-driven bench for demux4_seq at NP=1 (tick on every second edge).
module tb_demux4_seq;

    logic        clk;
    logic        rstn;
    logic [3:0]  din;
    logic        sync;
    logic [1:0]  sel;
    logic [15:0] dout;
    logic        frame;

    int checks = 0;
    int errors = 0;

    demux4_seq #(
        .NP (1)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .din   (din),
        .sync  (sync),
        .sel   (sel),
        .dout  (dout),
        .frame (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  din;
        logic [1:0]  sel;
        logic        frame;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] d, input logic [1:0] s, input logic f,
                       input logic [15:0] o);
        vec_t v;
        v.din = d; v.sel = s; v.frame = f; v.dout = o;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Drive din, take one rising edge, sample 1 time unit later.
    task automatic edge_with(input logic [3:0] d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    // Run up to max_edges from a fresh S0/pcnt=0 point; report the edge of the first frame.
    task automatic run_until_frame(input logic [3:0] p0, input logic [3:0] p1,
                                   input logic [3:0] p2, input logic [3:0] p3,
                                   input int max_edges, output int first,
                                   output logic [15:0] got_dout);
        logic [3:0] pat [4];
        pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
        first    = 0;
        got_dout = '0;
        for (int k = 1; k <= max_edges; k++) begin
            edge_with(pat[((k - 1) / 2) % 4]);
            if (frame && first == 0) begin
                first    = k;
                got_dout = dout;
            end
        end
    endtask

    int          first;
    logic [15:0] fdout;
    logic [15:0] last_dout;

    initial begin
        rstn = 1'b0;
        din  = 4'h0;
        sync = 1'b0;

        // Reset then idle.
        repeat (3) @(posedge clk);
        #1;
        check("reset_sel", {14'd0, sel}, 16'd0);
        check("reset_dout", dout, 16'h0000);
        check("reset_frame", {15'd0, frame}, 16'd0);
        rstn = 1'b1;

        // Three frames: 1,3,7,F twice, then 8,4,2,1.
        add(4'h1, 2'd0, 1'b0, 16'h0000); add(4'h1, 2'd1, 1'b0, 16'h0000);
        add(4'h3, 2'd1, 1'b0, 16'h0000); add(4'h3, 2'd2, 1'b0, 16'h0000);
        add(4'h7, 2'd2, 1'b0, 16'h0000); add(4'h7, 2'd3, 1'b0, 16'h0000);
        add(4'hF, 2'd3, 1'b0, 16'h0000); add(4'hF, 2'd0, 1'b1, 16'hF731);
        add(4'h1, 2'd0, 1'b0, 16'hF731); add(4'h1, 2'd1, 1'b0, 16'hF731);
        add(4'h3, 2'd1, 1'b0, 16'hF731); add(4'h3, 2'd2, 1'b0, 16'hF731);
        add(4'h7, 2'd2, 1'b0, 16'hF731); add(4'h7, 2'd3, 1'b0, 16'hF731);
        add(4'hF, 2'd3, 1'b0, 16'hF731); add(4'hF, 2'd0, 1'b1, 16'hF731);
        add(4'h8, 2'd0, 1'b0, 16'hF731); add(4'h8, 2'd1, 1'b0, 16'hF731);
        add(4'h4, 2'd1, 1'b0, 16'hF731); add(4'h4, 2'd2, 1'b0, 16'hF731);
        add(4'h2, 2'd2, 1'b0, 16'hF731); add(4'h2, 2'd3, 1'b0, 16'hF731);
        add(4'h1, 2'd3, 1'b0, 16'hF731); add(4'h1, 2'd0, 1'b1, 16'h1248);

        for (int i = 0; i < vecs.size(); i++) begin
            edge_with(vecs[i].din);
            check($sformatf("vec%0d_sel", i), {14'd0, sel}, {14'd0, vecs[i].sel});
            check($sformatf("vec%0d_frame", i), {15'd0, frame}, {15'd0, vecs[i].frame});
            check($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
        end

        // Reset mid-frame while in S2.
        edge_with(4'h5);
        edge_with(4'h5);
        edge_with(4'h6);
        edge_with(4'h6);
        check("pre_rst_sel", {14'd0, sel}, 16'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_sel", {14'd0, sel}, 16'd0);
        check("midrst_dout", dout, 16'h0000);
        check("midrst_frame", {15'd0, frame}, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_until_frame(4'h1, 4'h3, 4'h7, 4'hF, 20, first, fdout);
        check("midrst_first_frame_edge", 16'(first), 16'd8);
        check("midrst_first_frame_dout", fdout, 16'hF731);

        // Realign to a clean S0/pcnt=0 point with a reset.
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        run_until_frame(4'h1, 4'h3, 4'h7, 4'hF, 8, first, fdout);
        check("realign_frame_edge", 16'(first), 16'd8);
        last_dout = 16'hF731;

`ifdef DEMUX4_SYNC_EN
        // Sync pulse during S2 drops the partial frame.
        edge_with(4'h9);
        edge_with(4'h9);
        edge_with(4'hA);
        edge_with(4'hA);
        check("sync_pre_sel", {14'd0, sel}, 16'd2);
        sync = 1'b1;
        edge_with(4'hB);
        sync = 1'b0;
        check("sync_s2_sel", {14'd0, sel}, 16'd0);
        check("sync_s2_frame", {15'd0, frame}, 16'd0);
        check("sync_s2_dout", dout, 16'hF731);
        run_until_frame(4'h8, 4'h4, 4'h2, 4'h1, 8, first, fdout);
        check("sync_next_frame_edge", 16'(first), 16'd8);
        check("sync_next_frame_dout", fdout, 16'h1248);
        last_dout = 16'h1248;
`endif

        // Sync asserted on the S3 tick edge.
        edge_with(4'h2);
        edge_with(4'h2);
        edge_with(4'h4);
        edge_with(4'h4);
        edge_with(4'h6);
        edge_with(4'h6);
        edge_with(4'h8);
        check("s3_pre_sel", {14'd0, sel}, 16'd3);
        sync = 1'b1;
        edge_with(4'h8);
        sync = 1'b0;
        check("s3_sync_sel", {14'd0, sel}, 16'd0);
`ifdef DEMUX4_SYNC_EN
        check("s3_sync_frame", {15'd0, frame}, 16'd0);
        check("s3_sync_dout", dout, last_dout);
`else
        check("s3_nosync_frame", {15'd0, frame}, 16'd1);
        check("s3_nosync_dout", dout, 16'h8642);
`endif
        edge_with(4'h0);
        check("s3_after_frame", {15'd0, frame}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
